// File: rtl/uart_pkg.sv
// Shared UART definitions: the transmit FSM state type and the parity-mode
// constants, which the receive side uses as well.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_tx_state_t;

    localparam int PARITY_EVEN = 0;
    localparam int PARITY_ODD  = 1;

endpackage

// File: rtl/parity_gen.sv
// WIDTH-bit parity generator with an odd/even select.
// The receiver's checker uses this same block.
module parity_gen #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] data,
    input  logic             odd,
    output logic             parity
);

    // Even parity is the XOR reduction; odd parity is its complement.
    assign parity = (^data) ^ odd;

endmodule

// File: rtl/uart_tx.sv
// UART transmit serializer. Takes one word per valid/ready handshake and
// sends start, LSB-first data, optional parity and stop bit(s) on a registered tx.
module uart_tx #(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 1,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             tx_valid,
    input  logic [WIDTH-1:0] tx_data,
    output logic             tx_ready,
    output logic             tx,
    output logic             busy
);
    import uart_pkg::*;

    localparam int BIT_RANGE = (WIDTH > STOP_BITS) ? WIDTH : STOP_BITS;
    localparam int CLK_W     = ($clog2(CLKS_PER_BIT) > 0) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W     = ($clog2(BIT_RANGE) > 0) ? $clog2(BIT_RANGE) : 1;

    localparam logic [CLK_W-1:0] CLK_LAST  = CLK_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(WIDTH - 1);
    localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);
    localparam logic             ODD_SEL   = (PARITY_ODD != uart_pkg::PARITY_EVEN);

    uart_tx_state_t   state_reg, state_next;
    logic [CLK_W-1:0] clk_cnt_reg, clk_cnt_next;
    logic [BIT_W-1:0] bit_cnt_reg, bit_cnt_next;
    logic [WIDTH-1:0] shreg_reg, shreg_next;
    logic             parity_reg, parity_next;
    logic             tx_reg, tx_next;
    logic             accept;
    logic             bit_end;
    logic             par_bit;

    parity_gen #(
        .WIDTH (WIDTH)
    ) u_parity_gen (
        .data   (tx_data),
        .odd    (ODD_SEL),
        .parity (par_bit)
    );

    assign bit_end  = (clk_cnt_reg == CLK_LAST);
    assign tx_ready = (state_reg == IDLE) ||
                      ((state_reg == STOP) && (bit_cnt_reg == STOP_LAST) && bit_end);
    assign accept   = tx_valid && tx_ready;
    assign busy     = (state_reg != IDLE);
    assign tx       = tx_reg;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg   <= IDLE;
            clk_cnt_reg <= '0;
            bit_cnt_reg <= '0;
            shreg_reg   <= '0;
            parity_reg  <= 1'b0;
            tx_reg      <= 1'b1;
        end else begin
            state_reg   <= state_next;
            clk_cnt_reg <= clk_cnt_next;
            bit_cnt_reg <= bit_cnt_next;
            shreg_reg   <= shreg_next;
            parity_reg  <= parity_next;
            tx_reg      <= tx_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        clk_cnt_next = clk_cnt_reg;
        bit_cnt_next = bit_cnt_reg;
        shreg_next   = shreg_reg;
        parity_next  = parity_reg;

        // The line follows the current state one cycle later, so acceptance
        // at edge N shows the start bit from edge N+1.
        tx_next = 1'b1;
        case (state_reg)
            START:   tx_next = 1'b0;
            DATA:    tx_next = shreg_reg[0];
            PARITY:  tx_next = parity_reg;
            default: tx_next = 1'b1;
        endcase

        case (state_reg)
            IDLE: begin
                clk_cnt_next = '0;
                bit_cnt_next = '0;
                if (accept) begin
                    state_next  = START;
                    shreg_next  = tx_data;
                    parity_next = par_bit;
                end
            end
            START: begin
                if (bit_end) begin
                    state_next   = DATA;
                    clk_cnt_next = '0;
                    bit_cnt_next = '0;
                end else begin
                    clk_cnt_next = clk_cnt_reg + 1'b1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    clk_cnt_next = '0;
                    shreg_next   = shreg_reg >> 1;
                    if (bit_cnt_reg == DATA_LAST) begin
                        bit_cnt_next = '0;
                        state_next   = (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        bit_cnt_next = bit_cnt_reg + 1'b1;
                    end
                end else begin
                    clk_cnt_next = clk_cnt_reg + 1'b1;
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_next   = STOP;
                    clk_cnt_next = '0;
                    bit_cnt_next = '0;
                end else begin
                    clk_cnt_next = clk_cnt_reg + 1'b1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    clk_cnt_next = '0;
                    if (bit_cnt_reg == STOP_LAST) begin
                        bit_cnt_next = '0;
                        // A word taken in the last cycle chains straight into the next start bit.
                        if (accept) begin
                            state_next  = START;
                            shreg_next  = tx_data;
                            parity_next = par_bit;
                        end else begin
                            state_next = IDLE;
                        end
                    end else begin
                        bit_cnt_next = bit_cnt_reg + 1'b1;
                    end
                end else begin
                    clk_cnt_next = clk_cnt_reg + 1'b1;
                end
            end
            default: begin
                state_next   = IDLE;
                clk_cnt_next = '0;
                bit_cnt_next = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: four instances (even / odd / no parity / two stop bits),
// directed stimulus feeding per-instance expected-frame queues checked by line monitors.
module tb_uart_tx;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic [3:0] tx_valid = 4'b0000;
    logic [3:0] tx_ready;
    logic [3:0] tx;
    logic [3:0] busy;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int hs0      = 0;
    int start_q0[$];
    logic [11:0] exp_q[4][$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (rstn && tx_valid[0] && tx_ready[0]) hs0 <= hs0 + 1;

    uart_tx #(.WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) dut_even (
        .clk(clk), .rstn(rstn), .tx_valid(tx_valid[0]), .tx_data(tx_data),
        .tx_ready(tx_ready[0]), .tx(tx[0]), .busy(busy[0]));
    uart_tx #(.WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) dut_odd (
        .clk(clk), .rstn(rstn), .tx_valid(tx_valid[1]), .tx_data(tx_data),
        .tx_ready(tx_ready[1]), .tx(tx[1]), .busy(busy[1]));
    uart_tx #(.WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) dut_nopar (
        .clk(clk), .rstn(rstn), .tx_valid(tx_valid[2]), .tx_data(tx_data),
        .tx_ready(tx_ready[2]), .tx(tx[2]), .busy(busy[2]));
    uart_tx #(.WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) dut_stop2 (
        .clk(clk), .rstn(rstn), .tx_valid(tx_valid[3]), .tx_data(tx_data),
        .tx_ready(tx_ready[3]), .tx(tx[3]), .busy(busy[3]));

    // Frame in line order, bit 0 first; unused upper bits are idle-high.
    function automatic logic [11:0] mk(input logic [7:0] d, input logic p, input int i);
        logic [11:0] f;
        f = '1;
        f[0] = 1'b0;
        f[8:1] = d;
        if (i != 2) f[9] = p;
        return f;
    endfunction

    task automatic chk(input string name, input int got, input int exp);
        n_assert++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Line monitors: sample every negedge of each bit, require a stable bit, compare with the queue.
    for (genvar gi = 0; gi < 4; gi++) begin : mon
        localparam int PE = (gi == 2) ? 0 : 1;
        localparam int SB = (gi == 3) ? 2 : 1;
        localparam int NB = 1 + 8 + PE + SB;
        initial begin
            logic        prev;
            logic        first;
            logic        v;
            logic [11:0] got;
            logic [11:0] e;
            bit          stable;
            bit          aborted;
            prev = 1'b1;
            forever begin
                @(negedge clk);
                if (rstn && prev && !tx[gi]) begin
                    if (gi == 0) start_q0.push_back(cyc);
                    got = '1;
                    stable = 1'b1;
                    aborted = 1'b0;
                    first = 1'b0;
                    for (int b = 0; b < NB; b++) begin
                        for (int k = 0; k < CPB; k++) begin
                            if (b != 0 || k != 0) @(negedge clk);
                            if (!rstn) aborted = 1'b1;
                            if (aborted) break;
                            v = tx[gi];
                            if (k == 0) first = v;
                            else if (v != first) stable = 1'b0;
                        end
                        if (aborted) break;
                        got[b] = first;
                    end
                    if (!aborted) begin
                        n_assert++;
                        if (exp_q[gi].size() == 0) begin
                            n_fail++;
                            $display("FAIL frame_unexpected dut%0d: got %h expected no frame", gi, got);
                        end else begin
                            e = exp_q[gi].pop_front();
                            if (got !== e || !stable) begin
                                n_fail++;
                                $display("FAIL frame dut%0d: got %h (stable=%0d) expected %h", gi, got, stable, e);
                            end else begin
                                $display("frame dut%0d bits=%h ok", gi, got);
                            end
                        end
                    end
                end
                prev = tx[gi];
            end
        end
    end

    task automatic do_reset(input int cycles);
        rstn = 1'b0;
        repeat (cycles) @(negedge clk);
        rstn = 1'b1;
    endtask

    // Offer a word at a negedge; exp_len > 0 also measures busy cycles and the start-bit latency.
    task automatic send(input int i, input logic [7:0] d, input logic p, input int exp_len, input bit push);
        int t;
        int nb;
        t = 0;
        @(negedge clk);
        while (!tx_ready[i] && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) chk("ready_timeout", 0, 1);
        tx_data = d;
        tx_valid[i] = 1'b1;
        if (push) exp_q[i].push_back(mk(d, p, i));
        @(negedge clk);
        tx_valid[i] = 1'b0;
        tx_data = ~d;
        if (exp_len > 0) begin
            nb = busy[i] ? 1 : 0;
            chk("tx_high_after_accept", tx[i], 1);
            @(negedge clk);
            chk("tx_start_bit", tx[i], 0);
            while (busy[i] && nb < 300) begin
                nb++;
                @(negedge clk);
            end
            chk("busy_cycles", nb, exp_len);
            $display("sent dut%0d data=%h busy=%0d", i, d, nb);
        end
    endtask

    task automatic wait_idle(input int i);
        int t;
        t = 0;
        while ((exp_q[i].size() != 0 || busy[i]) && t < 400) begin
            @(negedge clk);
            t++;
        end
        repeat (4) @(negedge clk);
        chk("drain", exp_q[i].size(), 0);
    endtask

    initial begin
        int lows;
        int h0;
        int t;

        // Reset and idle line
        do_reset(3);
        @(negedge clk);
        chk("reset_tx", tx[0], 1);
        chk("reset_busy", busy[0], 0);
        chk("reset_ready", tx_ready[0], 1);
        lows = 0;
        repeat (20) begin
            @(negedge clk);
            if (!tx[0]) lows++;
        end
        chk("idle_tx_lows", lows, 0);

        // 0x55 even parity: parity 0, 44-cycle frame
        send(0, 8'h55, 1'b0, 44, 1'b1);
        wait_idle(0);

        // 0x07: odd -> parity 0, even -> parity 1, no parity -> 40 cycles
        send(1, 8'h07, 1'b0, 44, 1'b1);
        wait_idle(1);
        send(0, 8'h07, 1'b1, 44, 1'b1);
        wait_idle(0);
        send(2, 8'h07, 1'b0, 40, 1'b1);
        wait_idle(2);

        // Back-to-back with tx_valid held high: 0xA3 then 0x3C
        start_q0.delete();
        h0 = hs0;
        @(negedge clk);
        tx_data = 8'hA3;
        tx_valid[0] = 1'b1;
        exp_q[0].push_back(mk(8'hA3, 1'b0, 0));
        @(negedge clk);
        tx_data = 8'h3C;
        exp_q[0].push_back(mk(8'h3C, 1'b0, 0));
        t = 0;
        while (hs0 - h0 < 2 && t < 200) begin
            @(negedge clk);
            t++;
        end
        tx_valid[0] = 1'b0;
        wait_idle(0);
        chk("b2b_handshakes", hs0 - h0, 2);
        chk("b2b_start_count", start_q0.size(), 2);
        if (start_q0.size() == 2) chk("b2b_start_spacing", start_q0[1] - start_q0[0], 44);

        // 0xFF offered mid-frame of 0x12 must be ignored
        h0 = hs0;
        send(0, 8'h12, 1'b0, 0, 1'b1);
        repeat (9) @(negedge clk);
        tx_data = 8'hFF;
        tx_valid[0] = 1'b1;
        @(negedge clk);
        tx_valid[0] = 1'b0;
        wait_idle(0);
        repeat (50) @(negedge clk);
        chk("ignore_handshakes", hs0 - h0, 1);

        // Reset during DATA bit 3 (a 0 bit) of 0x52, then 0x81 with two stop bits
        send(3, 8'h52, 1'b1, 0, 1'b0);
        repeat (17) @(negedge clk);
        #1 rstn = 1'b0;
        #1;
        chk("midreset_tx", tx[3], 1);
        chk("midreset_ready", tx_ready[3], 1);
        chk("midreset_busy", busy[3], 0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        lows = 0;
        repeat (8) begin
            @(negedge clk);
            if (!tx[3]) lows++;
        end
        chk("post_reset_tx_lows", lows, 0);
        send(3, 8'h81, 1'b0, 48, 1'b1);
        wait_idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/uart_tx.md
# uart_tx

UART transmit serializer with parity generation, the transmit-side counterpart of the receive-side parity checker. It accepts a parallel word through a valid/ready handshake and drives one asynchronous serial frame on `tx`: start bit, data bits LSB-first, optional parity bit, then stop bit(s). It sits between the host-side data source and the serial pin, and its frame format matches what the UART receiver and its parity checker expect.

## Interface
- `WIDTH`, 8: data bits per frame.
- `CLKS_PER_BIT`, 16: `clk` cycles per serial bit. Must be ≥ 2.
- `PARITY_EN`, 1: 1 inserts a parity bit after the data bits; 0 omits it.
- `PARITY_ODD`, 0: 0 selects even parity; 1 selects odd parity.
- `STOP_BITS`, 1: number of stop bits, 1 or 2.
- `clk` input 1: single clock; all logic is on its rising edge.
- `rstn` input 1: asynchronous, active-low reset.
- `tx_valid` input 1: `tx_data` is offered for transmission.
- `tx_data` input WIDTH: word to send.
- `tx_ready` output 1: the block can accept a word this cycle.
- `tx` output 1: serial line; idles high.
- `busy` output 1: a frame is in progress.

## Operation
- Reset values: `tx`=1, `busy`=0, `tx_ready`=1; state is IDLE; all counters and the shift register are 0.
- Handshake: a word is accepted on a rising edge where `tx_valid && tx_ready`.
  - On acceptance, `tx_data` is latched into the shift register and the parity bit is computed and latched.
  - After acceptance, `tx_data` may change freely.
  - When `tx_ready`=0, `tx_valid` is ignored; there is no queueing.
- Parity: even gives `^tx_data`; odd gives `~^tx_data`. It is computed from the latched word.
- FSM states are IDLE, START, DATA, PARITY, STOP.
  - IDLE -> START on acceptance.
  - START -> DATA after CLKS_PER_BIT cycles.
  - DATA -> PARITY after WIDTH bits if PARITY_EN=1; otherwise DATA -> STOP.
  - PARITY -> STOP after one bit.
  - STOP -> IDLE after STOP_BITS bits, or STOP -> START if a new word is accepted in the final cycle of the frame.
- Line values by state: START drives 0; DATA drives shreg[0] and shifts right at each bit boundary; PARITY drives the latched parity bit; STOP drives 1.
- Counters:
  - `clk_cnt` runs 0..CLKS_PER_BIT-1 and wraps at each bit boundary.
  - `bit_cnt` runs 0..WIDTH-1 in DATA and 0..STOP_BITS-1 in STOP.
  - Counter widths are `$clog2` of their range, with a minimum of 1.
- `tx_ready` = (state==IDLE) || (state==STOP && bit_cnt==STOP_BITS-1 && clk_cnt==CLKS_PER_BIT-1).
- `busy` = (state != IDLE).
- Reset mid-frame: all outputs return immediately to their reset values and the partial frame is abandoned. No further edge occurs on `tx` until the next acceptance.

## Timing
- `tx` is registered. It falls on the first rising edge after the accepting edge; acceptance at edge N gives `tx`=0 from edge N+1.
- Each bit is held for exactly CLKS_PER_BIT cycles.
- Frame length is F = (1 + WIDTH + PARITY_EN + STOP_BITS) × CLKS_PER_BIT cycles.
- Back-to-back frames: if a word is accepted in the last cycle of the final stop bit, the next start bit follows with zero idle cycles. Frame period is exactly F.
- Throughput is one word per F cycles. `tx_ready` is low for F-1 of those F cycles when streaming.

## Structure
- Shared package `uart_pkg` holds:
  - the state enum `uart_tx_state_t` (IDLE, START, DATA, PARITY, STOP);
  - the constants `PARITY_EVEN`=0 and `PARITY_ODD`=1, shared with the receive side.
- One sub-module, `parity_gen`: a parameterised WIDTH-bit reduction plus an odd/even select. The same block is reusable by the receiver's checker.
- The FSM, counters and shift register live in `uart_tx`.

## Test plan
All scenarios use WIDTH=8 and CLKS_PER_BIT=4 unless stated.
- Reset: hold `rstn`=0 for 3 cycles, then release -> `tx`=1, `busy`=0, `tx_ready`=1. `tx` stays 1 for 20 idle cycles.
- 0x55 with even parity and 1 stop bit -> sampled per bit, `tx` is 0,1,0,1,0,1,0,1,0,0,1. The frame is 44 cycles; `busy` is high for 44 cycles.
- 0x07 with PARITY_ODD=1 -> parity bit 0; with even parity -> parity bit 1. With PARITY_EN=0 -> frame is 40 cycles and there is no parity bit.
- Back-to-back: hold `tx_valid` high with 0xA3 then 0x3C -> the second start bit begins immediately after the first stop bit. Start edges are exactly 44 cycles apart; exactly 2 handshakes occur.
- Busy ignore: pulse `tx_valid` with 0xFF in cycle 10 of a frame carrying 0x12 -> 0xFF is never transmitted and the 0x12 frame is unchanged.
- Reset mid-frame: assert `rstn`=0 during DATA bit 3 -> `tx`=1 and `tx_ready`=1 immediately. A subsequent 0x81 frame is sent correctly, with STOP_BITS=2 giving a 48-cycle frame.
